// File: rtl/dht11_sample_sched_if.sv
// Signal bundle between the DHT11 sample scheduler, its reader core and the downstream consumers.
// The master modport is the scheduler; the slave modport is whatever drives or observes it.
interface dht11_sample_sched_if;
  logic        enable;
  logic        trig_req;
  logic        err_clr;
  logic        start;
  logic        rd_done;
  logic [39:0] rd_frame;
  logic [7:0]  humidity_int;
  logic [7:0]  humidity_float;
  logic [7:0]  temperature_int;
  logic [7:0]  temperature_float;
  logic        data_valid;
  logic        data_upd;
  logic        err_checksum;
  logic        err_timeout;
  logic        fail;
  logic        busy;
  logic [15:0] sample_cnt;

  modport master (
    input  enable, trig_req, err_clr, rd_done, rd_frame,
    output start, humidity_int, humidity_float, temperature_int, temperature_float,
           data_valid, data_upd, err_checksum, err_timeout, fail, busy, sample_cnt
  );

  modport slave (
    output enable, trig_req, err_clr, rd_done, rd_frame,
    input  start, humidity_int, humidity_float, temperature_int, temperature_float,
           data_valid, data_upd, err_checksum, err_timeout, fail, busy, sample_cnt
  );
endinterface

// File: rtl/dht11_sample_sched.sv
// DHT11 sampling controller: periodic/on-demand start with a minimum inter-sample gap,
// response timeout, checksum validation, bounded retries and latched sensor readings.
module dht11_sample_sched #(
  parameter int unsigned SAMPLE_PERIOD = 50_000_000,
  parameter int unsigned MIN_GAP       = 25_000_000,
  parameter int unsigned RESP_TIMEOUT  = 2_500_000,
  parameter int unsigned MAX_RETRY     = 3,
  parameter int unsigned CNT_W         = 26
) (
  input  logic                       clk,
  input  logic                       rst,
  dht11_sample_sched_if.master       bus
);
  localparam int unsigned RETRY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
  localparam logic [CNT_W-1:0]   PERIOD_LAST = CNT_W'(SAMPLE_PERIOD - 1);
  localparam logic [CNT_W-1:0]   TMO_LAST    = CNT_W'(RESP_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]   GAP_LOAD    = CNT_W'(MIN_GAP);
  localparam logic [RETRY_W-1:0] RETRY_MAX   = RETRY_W'(MAX_RETRY);

  typedef enum logic [2:0] {S_IDLE, S_START, S_WAIT, S_CHECK, S_FAILURE} state_t;

  state_t             r_state, w_next;
  logic [CNT_W-1:0]   r_period, r_gap, r_tmo;
  logic               r_pending;
  logic [RETRY_W-1:0] r_retry_cnt;
  logic [39:0]        r_frame;
  logic [7:0]         r_hum_int, r_hum_flt, r_tmp_int, r_tmp_flt;
  logic               r_valid, r_upd, r_err_cs, r_err_to;
  logic [15:0]        r_sample_cnt;

  logic       w_timer_hit, w_tmo_hit, w_can_retry, w_frame_ok;
  logic [7:0] w_sum;

  assign w_timer_hit = bus.enable && (r_period == PERIOD_LAST);
  assign w_tmo_hit   = (r_tmo == TMO_LAST);
  assign w_can_retry = (r_retry_cnt < RETRY_MAX);
  assign w_sum       = r_frame[39:32] + r_frame[31:24] + r_frame[23:16] + r_frame[15:8];
  assign w_frame_ok  = (w_sum == r_frame[7:0]);

  // NOTE: every variable written here gets a default first, so no path can infer a latch.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (bus.enable && r_pending && (r_gap == '0)) w_next = S_START;
      S_START:   w_next = S_WAIT;
      S_WAIT:    if (bus.rd_done) w_next = S_CHECK;
                 else if (w_tmo_hit) w_next = S_FAILURE;
      S_CHECK:   w_next = w_frame_ok ? S_IDLE : S_FAILURE;
      S_FAILURE: w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Timers and request bookkeeping; a new request arriving on the START entry cycle is kept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_period    <= '0;
      r_gap       <= GAP_LOAD;
      r_tmo       <= '0;
      r_pending   <= 1'b0;
      r_retry_cnt <= '0;
      r_frame     <= '0;
    end else begin
      if (!bus.enable || w_timer_hit) r_period <= '0;
      else                            r_period <= r_period + CNT_W'(1);

      if (r_state == S_START)  r_gap <= GAP_LOAD;
      else if (r_gap != '0)    r_gap <= r_gap - CNT_W'(1);

      if (r_state == S_START)     r_tmo <= '0;
      else if (r_state == S_WAIT) r_tmo <= r_tmo + CNT_W'(1);

      if (w_timer_hit || (bus.trig_req && bus.enable) || (r_state == S_FAILURE && w_can_retry))
        r_pending <= 1'b1;
      else if (r_state == S_IDLE && w_next == S_START)
        r_pending <= 1'b0;

      if (r_state == S_CHECK && w_frame_ok) r_retry_cnt <= '0;
      else if (r_state == S_FAILURE)        r_retry_cnt <= w_can_retry ? r_retry_cnt + RETRY_W'(1) : '0;

      if (r_state == S_WAIT && bus.rd_done) r_frame <= bus.rd_frame;
    end
  end

  // Published readings and status; a flag being set outranks a same-cycle err_clr.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hum_int    <= '0;
      r_hum_flt    <= '0;
      r_tmp_int    <= '0;
      r_tmp_flt    <= '0;
      r_valid      <= 1'b0;
      r_upd        <= 1'b0;
      r_err_cs     <= 1'b0;
      r_err_to     <= 1'b0;
      r_sample_cnt <= '0;
    end else begin
      r_upd <= 1'b0;
      if (r_state == S_CHECK && w_frame_ok) begin
        r_hum_int    <= r_frame[39:32];
        r_hum_flt    <= r_frame[31:24];
        r_tmp_int    <= r_frame[23:16];
        r_tmp_flt    <= r_frame[15:8];
        r_valid      <= 1'b1;
        r_upd        <= 1'b1;
        r_sample_cnt <= r_sample_cnt + 16'd1;
      end

      if (r_state == S_CHECK && !w_frame_ok) r_err_cs <= 1'b1;
      else if (bus.err_clr)                  r_err_cs <= 1'b0;

      if (r_state == S_WAIT && !bus.rd_done && w_tmo_hit) r_err_to <= 1'b1;
      else if (bus.err_clr)                                r_err_to <= 1'b0;
    end
  end

  assign bus.start             = (r_state == S_START);
  assign bus.busy              = (r_state != S_IDLE);
  assign bus.fail              = (r_state == S_FAILURE) && !w_can_retry;
  assign bus.humidity_int      = r_hum_int;
  assign bus.humidity_float    = r_hum_flt;
  assign bus.temperature_int   = r_tmp_int;
  assign bus.temperature_float = r_tmp_flt;
  assign bus.data_valid        = r_valid;
  assign bus.data_upd          = r_upd;
  assign bus.err_checksum      = r_err_cs;
  assign bus.err_timeout       = r_err_to;
  assign bus.sample_cnt        = r_sample_cnt;
endmodule
